// File: rtl/counter_nb_full_if.sv
// counter_nb_full_if
//   Bundles the data-path and cascade signals of one counter_nb_full stage.
//   Clock and reset stay outside the interface as plain module ports.
//
//   Signal summary (master = driver of the stage, slave = the counter):
//     data    : parallel load value             (master -> slave)
//     load    : synchronous parallel load       (master -> slave)
//     down_up : 1 = count down, 0 = count up    (master -> slave)
//     hold_n  : 0 freezes the count             (master -> slave)
//     ci      : cascade enable from lower stage (master -> slave)
//     q       : registered count                (slave -> master)
//     tc      : terminal count, combinational   (slave -> master)
//     co      : cascade enable to next stage    (slave -> master)
//
//   There is no handshake: every input is sampled on each falling clock
//   edge, and the outputs are valid continuously (q after the edge, tc/co
//   combinationally from q and the current inputs).
interface counter_nb_full_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] data;
    logic             load;
    logic             down_up;
    logic             hold_n;
    logic             ci;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             co;

    modport master (
        output data, load, down_up, hold_n, ci,
        input  q, tc, co
    );

    modport slave (
        input  data, load, down_up, hold_n, ci,
        output q, tc, co
    );
endinterface

// File: rtl/counter_nb_full.sv
// counter_nb_full
//   N-bit synchronous up/down counter with parallel load, hold, asynchronous
//   clear, terminal-count flag and ripple-enable cascading (ci -> co), so
//   several stages can be chained into a wider counter.
//
//   Optional feature: define COUNTER_NB_MODULO_EN to make the count wrap
//   modulo MODULUS instead of 2**WIDTH (loads >= MODULUS store MODULUS-1).
//
//   Ports:
//     clock_n : the only clock; all state updates on its FALLING edge
//     reset_n : asynchronous active-low clear (q -> 0)
//     bus     : counter_nb_full_if.slave (data, load, down_up, hold_n, ci
//               in; q, tc, co out)
//
//   Update priority on each falling edge: load, then hold (hold_n=0 or
//   ci=0), then count in the direction given by down_up on that same edge.
module counter_nb_full #(
    parameter int              WIDTH   = 4,
    parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
    input  logic                   clock_n,
    input  logic                   reset_n,
    counter_nb_full_if.slave       bus
);

    // Reject illegal configurations at elaboration time.
    if (WIDTH < 2 || WIDTH > 32 || MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_param
        $error("counter_nb_full: illegal WIDTH/MODULUS combination");
    end

`ifdef COUNTER_NB_MODULO_EN
    // Highest reachable count; the wrap point in both directions.
    localparam logic [WIDTH-1:0] TOP = WIDTH'(MODULUS - 64'd1);
`else
    localparam logic [WIDTH-1:0] TOP = '1;
`endif

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_next;
    logic             w_tc;

    // Value stored by a parallel load.
    always_comb begin
        w_load_val = bus.data;
`ifdef COUNTER_NB_MODULO_EN
        // Out-of-range loads saturate to the top of the modulus.
        if ({{(64 - WIDTH){1'b0}}, bus.data} >= MODULUS) begin
            w_load_val = TOP;
        end
`endif
    end

    // Next-state selection in priority order. Explicit wrap checks keep the
    // natural build and the modulo build on one code path (TOP = all ones
    // gives the ordinary binary wrap).
    always_comb begin
        w_next = r_q;
        if (bus.load) begin
            w_next = w_load_val;
        end else if (!bus.hold_n || !bus.ci) begin
            w_next = r_q;
        end else if (!bus.down_up) begin
            w_next = (r_q == TOP) ? '0 : r_q + 1'b1;
        end else begin
            w_next = (r_q == '0) ? TOP : r_q - 1'b1;
        end
    end

    always_ff @(negedge clock_n or negedge reset_n) begin
        if (!reset_n) begin
            r_q <= '0;
        end else begin
            r_q <= w_next;
        end
    end

    // Terminal count follows the current direction, not the one in force
    // when q was last written.
    always_comb begin
        w_tc = bus.down_up ? (r_q == '0) : (r_q == TOP);
    end

    assign bus.q  = r_q;
    assign bus.tc = w_tc;
    assign bus.co = w_tc & bus.ci & bus.hold_n;

endmodule

// File: tb/tb_counter_nb_full.sv
// Directed bench for counter_nb_full: a single WIDTH=4 stage plus a
// two-stage cascade. Build with +define+COUNTER_NB_MODULO_EN to exercise
// the modulo feature (MODULUS=10) on the single stage.
module tb_counter_nb_full;

`ifdef COUNTER_NB_MODULO_EN
    localparam longint unsigned TB_MOD = 10;
`else
    localparam longint unsigned TB_MOD = 16;
`endif

    // ---------------- clock / reset ----------------
    logic clock_n = 1'b1;
    logic reset_n = 1'b1;
    always #5 clock_n = ~clock_n;

    // ---------------- DUTs ----------------
    counter_nb_full_if #(.WIDTH(4)) dut_if ();
    counter_nb_full_if #(.WIDTH(4)) lo_if ();
    counter_nb_full_if #(.WIDTH(4)) hi_if ();

    counter_nb_full #(.WIDTH(4), .MODULUS(TB_MOD)) dut (
        .clock_n (clock_n),
        .reset_n (reset_n),
        .bus     (dut_if.slave)
    );

    counter_nb_full #(.WIDTH(4), .MODULUS(16)) u_lo (
        .clock_n (clock_n),
        .reset_n (reset_n),
        .bus     (lo_if.slave)
    );

    counter_nb_full #(.WIDTH(4), .MODULUS(16)) u_hi (
        .clock_n (clock_n),
        .reset_n (reset_n),
        .bus     (hi_if.slave)
    );

    // High stage shares the control lines and takes its enable from lo co.
    assign hi_if.load    = lo_if.load;
    assign hi_if.down_up = lo_if.down_up;
    assign hi_if.hold_n  = lo_if.hold_n;
    assign hi_if.ci      = lo_if.co;

    // ---------------- checking ----------------
    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance to just after the next active (falling) edge.
    task automatic tick();
        @(negedge clock_n);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        dut_if.data    = '0;
        dut_if.load    = 1'b0;
        dut_if.down_up = 1'b0;
        dut_if.hold_n  = 1'b1;
        dut_if.ci      = 1'b1;
        lo_if.data     = '0;
        lo_if.load     = 1'b0;
        lo_if.down_up  = 1'b0;
        lo_if.hold_n   = 1'b1;
        lo_if.ci       = 1'b1;
        hi_if.data     = '0;

        // Reset asserted between edges: q clears at once.
        #2 reset_n = 1'b0;
        #1;
        chk("reset_q", 32'(dut_if.q), 0);
        chk("reset_tc_up", 32'(dut_if.tc), 0);
        chk("reset_co_up", 32'(dut_if.co), 0);
        dut_if.down_up = 1'b1;
        #1;
        chk("reset_tc_down", 32'(dut_if.tc), 1);
        chk("reset_co_down", 32'(dut_if.co), 1);
        dut_if.down_up = 1'b0;
        @(posedge clock_n);
        reset_n = 1'b1;

`ifdef COUNTER_NB_MODULO_EN
        // Up from 8: 9 (tc) then wrap to 0.
        dut_if.data = 4'd8;
        dut_if.load = 1'b1;
        tick();
        chk("mod_load8", 32'(dut_if.q), 8);
        chk("mod_tc8", 32'(dut_if.tc), 0);
        dut_if.load = 1'b0;
        tick();
        chk("mod_up9", 32'(dut_if.q), 9);
        chk("mod_tc9", 32'(dut_if.tc), 1);
        chk("mod_co9", 32'(dut_if.co), 1);
        tick();
        chk("mod_wrap0", 32'(dut_if.q), 0);
        chk("mod_tc0_up", 32'(dut_if.tc), 0);
        // Down from 0 wraps to MODULUS-1.
        dut_if.down_up = 1'b1;
        #1;
        chk("mod_tc0_down", 32'(dut_if.tc), 1);
        tick();
        chk("mod_down9", 32'(dut_if.q), 9);
        chk("mod_tc9_down", 32'(dut_if.tc), 0);
        tick();
        chk("mod_down8", 32'(dut_if.q), 8);
        // Out-of-range loads saturate.
        dut_if.data = 4'd12;
        dut_if.load = 1'b1;
        tick();
        chk("mod_load12", 32'(dut_if.q), 9);
        dut_if.data = 4'd15;
        tick();
        chk("mod_load15", 32'(dut_if.q), 9);
        dut_if.data = 4'd3;
        tick();
        chk("mod_load3", 32'(dut_if.q), 3);
        dut_if.load    = 1'b0;
        dut_if.down_up = 1'b0;
`else
        // Up count through the full range and wrap.
        for (int i = 1; i <= 16; i++) begin
            tick();
            chk("up_q", 32'(dut_if.q), 32'(i % 16));
            chk("up_tc", 32'(dut_if.tc), (i == 15) ? 32'd1 : 32'd0);
            chk("up_co", 32'(dut_if.co), (i == 15) ? 32'd1 : 32'd0);
        end

        // Load beats hold.
        dut_if.data = 4'd5;
        dut_if.load = 1'b1;
        tick();
        chk("load5", 32'(dut_if.q), 5);
        dut_if.hold_n = 1'b0;
        dut_if.data   = 4'd9;
        tick();
        chk("load_over_hold", 32'(dut_if.q), 9);
        dut_if.load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_q", 32'(dut_if.q), 9);
        end
        // ci=0 also holds.
        dut_if.hold_n = 1'b1;
        dut_if.ci     = 1'b0;
        tick();
        chk("ci0_hold", 32'(dut_if.q), 9);
        dut_if.ci = 1'b1;
        tick();
        chk("ci1_count", 32'(dut_if.q), 10);

        // co is gated by hold_n even when tc is high.
        dut_if.data = 4'd15;
        dut_if.load = 1'b1;
        tick();
        dut_if.load   = 1'b0;
        dut_if.hold_n = 1'b0;
        #1;
        chk("tc15_hold", 32'(dut_if.tc), 1);
        chk("co15_hold", 32'(dut_if.co), 0);
        dut_if.hold_n = 1'b1;

        // Down count and direction flip.
        dut_if.data    = 4'd2;
        dut_if.load    = 1'b1;
        dut_if.down_up = 1'b1;
        tick();
        chk("load2", 32'(dut_if.q), 2);
        dut_if.load = 1'b0;
        tick();
        chk("down1", 32'(dut_if.q), 1);
        chk("down1_tc", 32'(dut_if.tc), 0);
        tick();
        chk("down0", 32'(dut_if.q), 0);
        chk("down0_tc", 32'(dut_if.tc), 1);
        tick();
        chk("down15", 32'(dut_if.q), 15);
        chk("down15_tc", 32'(dut_if.tc), 0);
        dut_if.down_up = 1'b0;
        #1;
        chk("flip_tc15", 32'(dut_if.tc), 1);
        tick();
        chk("flip_up0", 32'(dut_if.q), 0);
        chk("flip_tc0", 32'(dut_if.tc), 0);
`endif

        // Reset mid-operation discards a pending load.
        tick();
        dut_if.data = 4'd7;
        dut_if.load = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("midreset_q", 32'(dut_if.q), 0);
        dut_if.load = 1'b0;
        #1 reset_n = 1'b1;
        tick();
        chk("after_reset_count", 32'(dut_if.q), 1);

        // Two-stage cascade behaves as one 8-bit counter.
        lo_if.data  = '0;
        hi_if.data  = '0;
        lo_if.load  = 1'b1;
        tick();
        chk("casc_load0", {24'd0, hi_if.q, lo_if.q}, 0);
        lo_if.load = 1'b0;
        for (int i = 1; i <= 261; i++) begin
            tick();
            chk("casc_q", {24'd0, hi_if.q, lo_if.q}, 32'(i % 256));
        end
        lo_if.ci = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("casc_freeze", {24'd0, hi_if.q, lo_if.q}, 5);
        end
        // Carry boundary: 0x0F -> 0x10 only through lo co.
        lo_if.data = 4'hF;
        hi_if.data = 4'h0;
        lo_if.load = 1'b1;
        lo_if.ci   = 1'b1;
        tick();
        lo_if.load = 1'b0;
        #1;
        chk("casc_lo_co", 32'(lo_if.co), 1);
        tick();
        chk("casc_carry", {24'd0, hi_if.q, lo_if.q}, 32'h10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/counter_nb_full.md
# counter_nb_full

Parametrised synchronous up/down binary counter. It is the N-bit successor of the 1-bit full counter cell. It supports:
- parallel load, hold and asynchronous clear;
- ripple-enable cascading through `ci`/`co`, so several instances can be chained into wider counters;
- a terminal-count flag;
- an optional programmable modulus.

It sits in the counter/timer datapath wherever the single-bit cells were chained by hand.

## Interface

Parameters:
- `WIDTH`, 4: counter width in bits; legal range 2..32.
- `MODULUS`, 2**WIDTH: count modulus. Only used when `COUNTER_NB_MODULO_EN` is defined; legal range 2..2**WIDTH.

Ports:
- `clock_n`  in  1: the only clock. All state updates on its falling edge.
- `reset_n`  in  1: asynchronous, active-low reset; release is not synchronised inside the block.
- `data`  in  WIDTH: parallel load value.
- `load`  in  1: synchronous parallel load, active high.
- `down_up`  in  1: direction; 1 = count down, 0 = count up.
- `hold_n`  in  1: 0 freezes the count; 1 allows counting.
- `ci`  in  1: cascade count enable from the less-significant stage; tie to 1 on the least-significant stage.
- `q`  out  WIDTH: registered count.
- `tc`  out  1: terminal count, combinational from `q` and `down_up`.
- `co`  out  1: cascade enable to the next stage, = `tc & ci & hold_n`.

## Operation

- Reset (`reset_n`=0): `q`=0 immediately, independent of `clock_n`.
  - `tc`=1 if `down_up`=1, else 0.
  - `co` = `tc & ci & hold_n`.
- On each falling edge of `clock_n` with `reset_n`=1, the first matching row applies (priority order):
  1. `load`=1: `q` <= `data`. Load ignores `hold_n` and `ci`.
  2. `hold_n`=0 or `ci`=0: `q` unchanged.
  3. `down_up`=0: `q` <= `q`+1, wrapping at the top (see Configuration).
  4. `down_up`=1: `q` <= `q`-1, wrapping at 0 (see Configuration).
- Terminal count:
  - Up mode: `tc`=1 when `q` = TOP.
  - Down mode: `tc`=1 when `q`=0.
  - TOP = 2**WIDTH-1, or MODULUS-1 when modulo mode is enabled.
- `co` is purely combinational. Chaining: stage k `ci` = stage k-1 `co`, with all stages sharing clock, reset, `load`, `down_up` and `hold_n`. A chain of M stages behaves as one counter of M*WIDTH bits (natural-wrap build).
- Changing direction on a clock edge: the new `down_up` value applies to that same edge. No extra cycle and no glitch on `q`.
- Arithmetic is modulo 2**WIDTH. No internal carry is kept beyond `co`.

## Timing

- Latency from `load`, `hold_n`, `ci` or `down_up` to `q`: one falling edge of `clock_n`.
- Latency from `reset_n` assertion to `q`=0: zero cycles (asynchronous).
- First counting edge: the first falling edge after `reset_n` deasserts may count. The integrator must release `reset_n` away from the falling edge of `clock_n`.
- `tc` and `co` settle combinationally within the same cycle as `q`, `down_up`, `ci` and `hold_n`. There is no registered delay on either.
- Reset mid-operation: the count is lost. Any `load` active at that moment is discarded.

## Configuration

- `COUNTER_NB_MODULO_EN` defined:
  - The count wraps modulo `MODULUS`: up from MODULUS-1 to 0, down from 0 to MODULUS-1.
  - TOP = MODULUS-1.
  - A load with `data` >= MODULUS stores MODULUS-1.
- `COUNTER_NB_MODULO_EN` not defined:
  - `MODULUS` is ignored.
  - Natural binary wrap at 2**WIDTH.
  - `load` stores `data` unmodified.

## Test plan

- Reset: WIDTH=4, `down_up`=0, pulse `reset_n` low between clock edges -> `q`=0 immediately, `tc`=0. Set `down_up`=1 -> `tc`=1.
- Up count and wrap: `ci`=1, `hold_n`=1, `down_up`=0, 16 edges from 0 -> `q` runs 1..15 then 0; `tc`=`co`=1 only while `q`=15.
- Load priority: `q`=5, `load`=1, `hold_n`=0, `data`=9 -> `q`=9 after one edge. Then `load`=0 with `hold_n`=0 for 3 edges -> `q` stays 9.
- Down count and direction flip: load 2, `down_up`=1 for 3 edges -> `q` = 1, 0, 15, with `tc`=1 while `q`=0. Flip to up -> `q`=0 on the next edge.
- Cascade: two WIDTH=4 stages chained, up mode, 256 edges from 0 -> combined `q` steps 0..255 and wraps. The high stage increments only when the low stage `co`=1. Drop `ci`=0 on the low stage -> both stages freeze.
- Modulo (`COUNTER_NB_MODULO_EN`, MODULUS=10):
  - Up from 8 -> `q` = 9, 0; `tc`=1 at 9.
  - Down from 0 -> `q`=9.
  - Load 12 -> `q`=9.
